clock_reader: RTL and testbench

CLOCK_READER -- requirements
Module: clock_reader

---
 rtl/clock_reader.sv | 277 +++++++++++++++++++++++++++
 tb/tb_clock_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_reader.sv
// -----------------------------------------------------------------------------
// clock_reader
//
// Reads an HH:MM:SS time value back from a rendered frame buffer. Eight
// character cells (digit, digit, colon, digit, digit, colon, digit, digit) are
// scanned column by column. Each 13-pixel column is matched against the
// matching column of all 11 glyphs in a character ROM (digits 0..9, colon=10).
// A glyph survives only if every column matches. Once all cells are decoded,
// the three fields are range-checked and published on time_out.
//
// Optional feature (compile-time macro):
//   CLOCK_READER_STRICT_PIXEL_EN  defined   : pixel must be exactly 24'hFFFFFF
//                                             (white) or 24'h000000 (black);
//                                             anything else is a decode error.
//                                 undefined : pixel bit is IM_Q[23].
//
// Ports:
//   clk       in   1   clock
//   reset     in   1   asynchronous, active-high reset
//   start     in   1   request one readback, honoured only in IDLE
//   FB_Addr   in  20   frame buffer base offset, sampled when start is accepted
//   IM_A      out 20   image memory address (registered)
//   IM_Q      in  24   pixel data, valid one cycle after IM_A
//   IM_WEN    out  1   image memory write enable, tied to 1 (read only)
//   CR_A      out  9   character ROM address (registered)
//   CR_Q      in  13   glyph column word, valid one cycle after CR_A
//   busy      out  1   scan in progress (scan and CHECK cycles)
//   done      out  1   one-cycle completion pulse
//   err       out  1   decode/range error, valid from done until next run
//   time_out  out 24   {hours, minutes, seconds}, 8-bit binary each
// -----------------------------------------------------------------------------
module clock_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] FB_Addr,
    output logic [19:0] IM_A,
    input  logic [23:0] IM_Q,
    output logic        IM_WEN,
    output logic [8:0]  CR_A,
    input  logic [12:0] CR_Q,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] time_out
);

    typedef enum logic [2:0] {
        IDLE,
        COL_RD,
        ROM_CMP,
        CHECK,
        DONE
    } state_t;

    localparam logic [19:0] TEXT_OFFSET = 20'd59544;
    localparam logic [3:0]  COLON_GLYPH = 4'd10;

    state_t      state, state_nxt;
    logic [3:0]  cyc, cyc_nxt;      // cycle within the current phase
    logic [4:0]  col, col_nxt;      // column c, 0..23
    logic [2:0]  chr, chr_nxt;      // character position n, 0..7
    logic [19:0] base, base_nxt;
    logic [19:0] im_a_nxt;
    logic [8:0]  cr_a_nxt;

    logic [12:0] pix;               // captured column, row 0 ends up in bit 12
    logic [10:0] cand;              // surviving glyph candidates
    logic [10:0] cand_cmp;          // cand after this cycle's compare
    logic [3:0]  k_idx;
    logic        dec_err;           // sticky decode error for the current run
    logic [3:0]  digit [0:7];

    logic        pix_bit;
    logic        pix_bad;
    logic [3:0]  glyph_idx;
    logic        glyph_found;
    logic        glyph_multi;
    logic        glyph_ok;

    logic [7:0]  hours, minutes, seconds;
    logic        range_bad;

    assign IM_WEN = 1'b1;

    // -------------------------------------------------------------------------
    // Next-state and loop counters
    // -------------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        col_nxt   = col;
        chr_nxt   = chr;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COL_RD;
                    cyc_nxt   = 4'd0;
                    col_nxt   = 5'd0;
                    chr_nxt   = 3'd0;
                end
            end
            COL_RD: begin
                if (cyc == 4'd13) begin
                    state_nxt = ROM_CMP;
                    cyc_nxt   = 4'd0;
                end else begin
                    cyc_nxt = cyc + 4'd1;
                end
            end
            ROM_CMP: begin
                if (cyc == 4'd11) begin
                    cyc_nxt = 4'd0;
                    if (col == 5'd23) begin
                        col_nxt = 5'd0;
                        if (chr == 3'd7) begin
                            state_nxt = CHECK;
                        end else begin
                            chr_nxt   = chr + 3'd1;
                            state_nxt = COL_RD;
                        end
                    end else begin
                        col_nxt   = col + 5'd1;
                        state_nxt = COL_RD;
                    end
                end else begin
                    cyc_nxt = cyc + 4'd1;
                end
            end
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are registered, so they are computed from the next-cycle
    // counters; during cycle r the pixel/ROM address for step r is on the bus.
    always_comb begin
        base_nxt = (state == IDLE && start) ? FB_Addr : base;
        im_a_nxt = base_nxt + TEXT_OFFSET + {7'd0, col_nxt, 8'd0}
                 + 20'(chr_nxt) * 20'd13 + 20'(cyc_nxt);
        cr_a_nxt = 9'(cyc_nxt) * 9'd24 + 9'(col_nxt);
    end

    // -------------------------------------------------------------------------
    // Pixel classification
    // -------------------------------------------------------------------------
`ifdef CLOCK_READER_STRICT_PIXEL_EN
    always_comb begin
        pix_bit = (IM_Q == 24'hFFFFFF);
        pix_bad = (IM_Q != 24'hFFFFFF) && (IM_Q != 24'h000000);
    end
`else
    always_comb begin
        pix_bit = IM_Q[23];
        pix_bad = 1'b0;
    end
`endif

    // -------------------------------------------------------------------------
    // Column compare and glyph decode
    // -------------------------------------------------------------------------
    // pix is shifted in from the LSB, so row r sits at bit 12-r, which lines
    // up directly with CR_Q[12-r]; the whole column compares as one word.
    always_comb begin
        k_idx    = cyc - 4'd1;
        cand_cmp = cand;
        if (state == ROM_CMP && cyc != 4'd0 && CR_Q != pix) begin
            cand_cmp[k_idx] = 1'b0;
        end
    end

    always_comb begin
        glyph_idx   = 4'd0;
        glyph_found = 1'b0;
        glyph_multi = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (cand_cmp[i]) begin
                if (glyph_found) glyph_multi = 1'b1;
                glyph_found = 1'b1;
                glyph_idx   = 4'(i);
            end
        end
        if (!glyph_found || glyph_multi) begin
            glyph_ok = 1'b0;
        end else if (chr == 3'd2 || chr == 3'd5) begin
            glyph_ok = (glyph_idx == COLON_GLYPH);
        end else begin
            glyph_ok = (glyph_idx <= 4'd9);
        end
    end

    // -------------------------------------------------------------------------
    // Field assembly and range check
    // -------------------------------------------------------------------------
    always_comb begin
        hours     = 8'(digit[0]) * 8'd10 + 8'(digit[1]);
        minutes   = 8'(digit[3]) * 8'd10 + 8'(digit[4]);
        seconds   = 8'(digit[6]) * 8'd10 + 8'(digit[7]);
        range_bad = (hours > 8'd23) || (minutes > 8'd59) || (seconds > 8'd59);
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cyc      <= 4'd0;
            col      <= 5'd0;
            chr      <= 3'd0;
            base     <= 20'd0;
            IM_A     <= 20'd0;
            CR_A     <= 9'd0;
            pix      <= 13'd0;
            cand     <= 11'd0;
            dec_err  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            time_out <= 24'd0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            col   <= col_nxt;
            chr   <= chr_nxt;
            base  <= base_nxt;
            busy  <= (state_nxt == COL_RD) || (state_nxt == ROM_CMP)
                  || (state_nxt == CHECK);
            done  <= (state_nxt == DONE);

            if (state_nxt == COL_RD)  IM_A <= im_a_nxt;
            if (state_nxt == ROM_CMP) CR_A <= cr_a_nxt;

            unique case (state)
                IDLE: begin
                    if (start) dec_err <= 1'b0;
                end
                COL_RD: begin
                    if (cyc == 4'd0 && col == 5'd0) cand <= '1;
                    if (cyc != 4'd0) begin
                        pix <= {pix[11:0], pix_bit};
                        if (pix_bad) dec_err <= 1'b1;
                    end
                end
                ROM_CMP: begin
                    cand <= cand_cmp;
                    if (cyc == 4'd11 && col == 5'd23 && !glyph_ok) begin
                        dec_err <= 1'b1;
                    end
                end
                CHECK: begin
                    if (dec_err || range_bad) begin
                        err <= 1'b1;
                    end else begin
                        err      <= 1'b0;
                        time_out <= {hours, minutes, seconds};
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the digit file is deliberately not reset; every entry is written
    // at the end of its character before CHECK reads it.
    always_ff @(posedge clk) begin
        if (state == ROM_CMP && cyc == 4'd11 && col == 5'd23) begin
            digit[chr] <= glyph_idx;
        end
    end

endmodule

// File: tb/tb_clock_reader.sv
// -----------------------------------------------------------------------------
// tb_clock_reader
//
// Directed bench for clock_reader. Provides a synchronous-read frame buffer
// and character ROM (font words produced by a fixed hash, so every glyph is
// distinct), paints time strings into the frame, and checks each completed
// readback against a scoreboard entry pushed when the run was started.
// -----------------------------------------------------------------------------
module tb_clock_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] FB_Addr;
    logic [19:0] IM_A;
    logic [23:0] IM_Q;
    logic        IM_WEN;
    logic [8:0]  CR_A;
    logic [12:0] CR_Q;
    logic        busy;
    logic        done;
    logic        err;
    logic [23:0] time_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] t;
        logic        e;
    } exp_t;

    exp_t sb[$];

    logic [23:0] fb  [0:(1 << 17) - 1];
    logic [12:0] rom [0:511];

    clock_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .FB_Addr  (FB_Addr),
        .IM_A     (IM_A),
        .IM_Q     (IM_Q),
        .IM_WEN   (IM_WEN),
        .CR_A     (CR_A),
        .CR_Q     (CR_Q),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .time_out (time_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        IM_Q <= fb[IM_A[16:0]];
        CR_Q <= rom[CR_A];
    end

    function automatic logic [12:0] font(input int a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E3779B1 + 32'h01234567;
        x = x ^ (x >> 13);
        x = x * 32'h85EBCA6B;
        x = x ^ (x >> 16);
        return x[12:0];
    endfunction

    function automatic logic [16:0] pix_addr(input logic [19:0] base, input int n,
                                             input int c, input int r);
        logic [19:0] a;
        a = base + 20'd59544 + 20'(c * 256) + 20'(13 * n) + 20'(r);
        return a[16:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // glyphs = {g0, g1, ..., g7}, one nibble per character position.
    task automatic draw(input logic [19:0] base, input logic [31:0] glyphs);
        logic [3:0]  g;
        logic [12:0] w;
        for (int n = 0; n < 8; n++) begin
            g = glyphs[28 - 4 * n +: 4];
            for (int c = 0; c < 24; c++) begin
                w = font(int'(g) * 24 + c);
                for (int r = 0; r < 13; r++) begin
                    fb[pix_addr(base, n, c, r)] = w[12 - r] ? 24'hFFFFFF : 24'h000000;
                end
            end
        end
    endtask

    task automatic run_scan(input string tag, input logic [19:0] base,
                            input logic [23:0] exp_time, input logic exp_err);
        int   cyc;
        logic busy_last;
        exp_t e;
        sb.push_back('{t: exp_time, e: exp_err});
        @(negedge clk);
        FB_Addr = base;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        FB_Addr = 20'hABCDE;   // must not matter once sampled
        cyc     = 1;
        check({tag, " busy_c1"}, 32'(busy), 32'd1);
        busy_last = 1'b0;
        while (!done && cyc < 6000) begin
            start = (cyc == 100);   // ignored mid-scan
            if (cyc == 4993) busy_last = busy;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, 32'(cyc), 32'd4994);
        check({tag, " busy_c4993"}, 32'(busy_last), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        e = sb.pop_front();
        check({tag, " time_out"}, 32'(time_out), 32'(e.t));
        check({tag, " err"}, 32'(err), 32'(e.e));
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " start_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic        seen_done;
        int          black_r;
        logic [12:0] w;

        reset   = 1'b1;
        start   = 1'b0;
        FB_Addr = 20'd0;
        for (int a = 0; a < 512; a++) rom[a] = font(a);
        for (int a = 0; a < (1 << 17); a++) fb[a] = 24'h000000;

        repeat (3) @(negedge clk);
        check("rst IM_A", 32'(IM_A), 32'd0);
        check("rst CR_A", 32'(CR_A), 32'd0);
        check("rst time_out", 32'(time_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst IM_WEN", 32'(IM_WEN), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 12:34:56 at base 0
        draw(20'd0, 32'h12A34A56);
        run_scan("t123456", 20'd0, 24'h0C2238, 1'b0);

        // 23:59:59 at base 0x100
        draw(20'h00100, 32'h23A59A59);
        run_scan("t235959", 20'h00100, 24'h173B3B, 1'b0);

        // one colon pixel at position 2 inverted
        draw(20'd0, 32'h12A34A56);
        fb[pix_addr(20'd0, 2, 5, 6)] = ~fb[pix_addr(20'd0, 2, 5, 6)];
        run_scan("colon_bad", 20'd0, 24'h173B3B, 1'b1);

        // hours 27 is out of range
        draw(20'd0, 32'h27A59A59);
        run_scan("hour_rng", 20'd0, 24'h173B3B, 1'b1);

        // one black pixel replaced by mid-grey
        draw(20'd0, 32'h12A34A56);
        w = font(1 * 24 + 0);
        black_r = 0;
        for (int r = 12; r >= 0; r--) if (!w[12 - r]) black_r = r;
        fb[pix_addr(20'd0, 0, 0, black_r)] = 24'h7F7F7F;
`ifdef CLOCK_READER_STRICT_PIXEL_EN
        run_scan("grey_pix", 20'd0, 24'h173B3B, 1'b1);
`else
        run_scan("grey_pix", 20'd0, 24'h0C2238, 1'b0);
`endif

        // reset at cycle 2000 of a scan, then a clean 00:00:00 scan
        draw(20'd0, 32'h00A00A00);
        @(negedge clk);
        FB_Addr = 20'd0;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        seen_done = 1'b0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) seen_done = 1'b1;
        end
        reset = 1'b1;
        #1;
        check("midrst IM_A", 32'(IM_A), 32'd0);
        check("midrst CR_A", 32'(CR_A), 32'd0);
        check("midrst time_out", 32'(time_out), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst no_done", 32'(seen_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_scan("rerun", 20'd0, 24'h000000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
